// File: rtl/sonar_wb_sample_fifo.sv
// rtl/sonar_wb_sample_fifo.sv - sonar sample capture FIFO drained over Wishbone, with threshold IRQ
// Registers: DATA (pop), STATUS, CTRL (en/irq_en/thresh), CMD (clear ovf / flush).
module sonar_wb_sample_fifo #(
   parameter int          DW       = 16,
   parameter int          DEPTH    = 16,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   input  logic          sample_valid_i,
   input  logic [DW-1:0] sample_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic          irq_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_CMD    = 2'd3
   } reg_e;

   logic          ack_q, ack_d;
   logic          req_we_q, req_we_d;
   reg_e          req_reg_q, req_reg_d;
   logic [1:0]    req_sel_q, req_sel_d;
   logic [9:0]    req_wdat_q, req_wdat_d;
   logic          en_q, en_d;
   logic          irq_en_q, irq_en_d;
   logic [7:0]    thresh_q, thresh_d;
   logic          ovf_q, ovf_d;
   logic          irq_q, irq_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic          hit, req;
   logic          rd_acc, wr_acc;
   logic [AW:0]   count, count_d;
   logic          empty, full;
   logic          pop, flush, ovf_clr;
   logic          push_try, push_ok, ovf_set;
   logic [31:0]   rdata;
   logic          unused_bits;

   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_dat_i[7:2], wbs_sel_i[3:2]};

   always_comb begin
      hit = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
      req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;

      // Request attributes are held until the ack cycle, where the access takes effect.
      ack_d      = req;
      req_we_d   = req_we_q;
      req_reg_d  = req_reg_q;
      req_sel_d  = req_sel_q;
      req_wdat_d = req_wdat_q;
      if (req) begin
         req_we_d   = wbs_we_i;
         req_reg_d  = reg_e'(wbs_adr_i[3:2]);
         req_sel_d  = wbs_sel_i[1:0];
         req_wdat_d = {wbs_dat_i[15:8], wbs_dat_i[1:0]};
      end

      rd_acc = ack_q & ~req_we_q;
      wr_acc = ack_q & req_we_q;

      count = wr_ptr_q - rd_ptr_q;
      empty = (count == '0);
      full  = (count == DEPTH_P);

      pop     = rd_acc & (req_reg_q == REG_DATA) & ~empty;
      flush   = wr_acc & (req_reg_q == REG_CMD) & req_wdat_q[1];
      ovf_clr = wr_acc & (req_reg_q == REG_CMD) & req_wdat_q[0];

      // A same-cycle pop frees a slot for the push; a flush discards it.
      push_try = sample_valid_i & en_q;
      push_ok  = push_try & (~full | pop) & ~flush;
      ovf_set  = push_try & full & ~pop & ~flush;

      wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop);
      ovf_d    = ovf_set | (ovf_q & ~ovf_clr);

      en_d     = en_q;
      irq_en_d = irq_en_q;
      thresh_d = thresh_q;
      if (wr_acc && (req_reg_q == REG_CTRL)) begin
         if (req_sel_q[0]) begin
            en_d     = req_wdat_q[0];
            irq_en_d = req_wdat_q[1];
         end
         if (req_sel_q[1]) begin
            thresh_d = req_wdat_q[9:2];
         end
      end

      // IRQ tracks the post-update state so it moves on the same edge as count.
      count_d = wr_ptr_d - rd_ptr_d;
      irq_d   = irq_en_d & (((thresh_d != 8'd0) & (16'(count_d) >= 16'(thresh_d))) | ovf_d);

      rdata = '0;
      case (req_reg_q)
         REG_DATA: begin
            if (!empty) begin
               rdata[DW-1:0] = mem_q[rd_ptr_q[AW-1:0]];
            end
         end
         REG_STATUS: begin
            rdata[31:16] = 16'(count);
            rdata[2]     = ovf_q;
            rdata[1]     = full;
            rdata[0]     = empty;
         end
         REG_CTRL: begin
            rdata[15:8] = thresh_q;
            rdata[1]    = irq_en_q;
            rdata[0]    = en_q;
         end
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_q      <= 1'b0;
         req_we_q   <= 1'b0;
         req_reg_q  <= REG_DATA;
         req_sel_q  <= '0;
         req_wdat_q <= '0;
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         thresh_q   <= '0;
         ovf_q      <= 1'b0;
         irq_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         ack_q      <= ack_d;
         req_we_q   <= req_we_d;
         req_reg_q  <= req_reg_d;
         req_sel_q  <= req_sel_d;
         req_wdat_q <= req_wdat_d;
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         thresh_q   <= thresh_d;
         ovf_q      <= ovf_d;
         irq_q      <= irq_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= sample_i;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rd_acc ? rdata : 32'd0;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_sonar_wb_sample_fifo.sv
// tb/tb_sonar_wb_sample_fifo.sv - scoreboard bench for sonar_wb_sample_fifo
// Queue-based FIFO model; read expectations are queued at issue and checked on ack.
module tb_sonar_wb_sample_fifo;

   localparam int          DW    = 16;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic          clk;
   logic          rst_n;
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic          stb, cyc, we;
   logic [3:0]    sel;
   logic [31:0]   adr, dat_w;
   logic          ack;
   logic [31:0]   dat_r;
   logic          irq;

   sonar_wb_sample_fifo #(.DW(DW), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
      .wb_clk_i       (clk),
      .wb_rst_n_i     (rst_n),
      .sample_valid_i (sample_valid),
      .sample_i       (sample),
      .wbs_stb_i      (stb),
      .wbs_cyc_i      (cyc),
      .wbs_we_i       (we),
      .wbs_sel_i      (sel),
      .wbs_adr_i      (adr),
      .wbs_dat_i      (dat_w),
      .wbs_ack_o      (ack),
      .wbs_dat_o      (dat_r),
      .irq_o          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      bit          is_rd;
      int          tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   tag_cnt = 0;

   logic [DW-1:0] m_q[$];
   bit            m_ovf, m_en, m_irq_en;
   logic [7:0]    m_thresh;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] m_status();
      return {16'(m_q.size()), 13'd0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
   endfunction

   function automatic logic [31:0] m_ctrl();
      return {16'd0, m_thresh, 6'd0, m_irq_en, m_en};
   endfunction

   function automatic logic m_irq();
      return m_irq_en && ((m_thresh != 0 && m_q.size() >= int'(m_thresh)) || m_ovf);
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_ovf = 0; m_en = 0; m_irq_en = 0; m_thresh = 8'd0;
   endtask

   // Monitor: every ack consumes one scoreboard entry; idle cycles must show zero data.
   initial begin
      forever begin
         @(negedge clk);
         if (ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_rd) check($sformatf("rd_data_%0d", mon_e.tag), dat_r, mon_e.val);
            end
         end else begin
            check("dat_idle", dat_r, 32'd0);
         end
      end
   end

   task automatic push(input logic [DW-1:0] v);
      sample_valid = 1'b1;
      sample       = v;
      @(negedge clk);
      sample_valid = 1'b0;
      if (m_en) begin
         if (m_q.size() < DEPTH) m_q.push_back(v);
         else m_ovf = 1;
      end
   endtask

   task automatic xfer(input bit w, input logic [3:0] off, input logic [31:0] d,
                       input logic [3:0] s, input bit co_push, input logic [DW-1:0] co_val);
      exp_t e;
      int   lat;
      bit   popm, flush, clr, set;
      e.is_rd = !w;
      e.tag   = tag_cnt++;
      e.val   = 32'd0;
      if (!w) begin
         case (off)
            4'h0:    e.val = (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0;
            4'h4:    e.val = m_status();
            4'h8:    e.val = m_ctrl();
            default: e.val = 32'd0;
         endcase
      end
      exp_q.push_back(e);
      cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + 32'(off); dat_w = d; sel = s;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ack && lat < 8);
      check("ack_latency", 32'(lat), 32'd1);
      if (!ack) exp_q.delete();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (co_push) begin
         sample_valid = 1'b1;
         sample       = co_val;
      end
      popm  = !w && off == 4'h0 && m_q.size() > 0;
      flush = w && off == 4'hC && d[1];
      clr   = w && off == 4'hC && d[0];
      set   = 0;
      if (popm) void'(m_q.pop_front());
      if (flush) m_q.delete();
      else if (co_push && m_en) begin
         if (m_q.size() < DEPTH) m_q.push_back(co_val);
         else set = 1;
      end
      m_ovf = set || (m_ovf && !clr);
      if (w && off == 4'h8) begin
         if (s[0]) begin m_en = d[0]; m_irq_en = d[1]; end
         if (s[1]) m_thresh = d[15:8];
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] off);
      xfer(1'b0, off, 32'd0, 4'h0, 1'b0, '0);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      xfer(1'b1, off, d, 4'hF, 1'b0, '0);
   endtask

   task automatic chk_irq(input string name);
      check(name, 32'(irq), 32'(m_irq()));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; sample = '0;
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_dat", dat_r, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      rd(4'h4);
      rd(4'h0);

      wr(4'h8, 32'h0000_0401);
      rd(4'h8);
      push(16'h1234); push(16'hBEEF); push(16'h0007);
      rd(4'h0); rd(4'h0); rd(4'h0);
      rd(4'h4);

      for (int i = 0; i < DEPTH + 2; i++) push(16'(i + 16'h100));
      rd(4'h4);
      rd(4'h0);
      push(16'h0AAA);
      rd(4'h4);
      wr(4'hC, 32'h1);
      rd(4'h4);
      wr(4'hC, 32'h2);
      rd(4'h4);

      wr(4'h8, 32'h0000_0403);
      for (int i = 0; i < 3; i++) begin
         push(16'(i + 16'h40));
         chk_irq("irq_below_thresh");
      end
      push(16'h0043);
      chk_irq("irq_at_thresh");
      rd(4'h0);
      chk_irq("irq_after_pop");

      wr(4'hC, 32'h2);
      wr(4'h8, 32'h0000_0001);
      for (int i = 0; i < DEPTH; i++) push(16'(i + 16'h200));
      for (int i = 0; i < 5; i++) xfer(1'b0, 4'h0, 32'd0, 4'h0, 1'b1, 16'($urandom));
      rd(4'h4);
      for (int i = 0; i < DEPTH; i++) rd(4'h0);
      xfer(1'b0, 4'h0, 32'd0, 4'h0, 1'b1, 16'h5A5A);
      rd(4'h4);

      push(16'h0111);
      xfer(1'b1, 4'hC, 32'h2, 4'hF, 1'b1, 16'h0222);
      rd(4'h4);

      for (int i = 0; i < DEPTH; i++) push(16'($urandom));
      xfer(1'b1, 4'hC, 32'h1, 4'hF, 1'b1, 16'h0333);
      rd(4'h4);

      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("miss_ack", 32'(ack), 32'd0);
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);

      wr(4'h8, 32'h0000_0003);
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: push(16'($urandom));
            3, 4:    rd(4'h0);
            5:       xfer(1'b0, 4'h0, 32'd0, 4'h0, 1'b1, 16'($urandom));
            6:       rd(4'h4);
            7:       xfer(1'b1, 4'hC, 32'($urandom_range(0, 3)), 4'hF,
                          1'($urandom_range(0, 1)), 16'($urandom));
            8: begin
               xfer(1'b1, 4'h8,
                    {16'($urandom), 8'($urandom_range(0, 20)), 6'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)},
                    4'($urandom), 1'b0, '0);
               rd(4'h8);
            end
            default: @(negedge clk);
         endcase
         chk_irq("irq_random");
      end

      wr(4'h8, 32'h0000_0503);
      push(16'h0F0F); push(16'h0E0E);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4;
      @(posedge clk);
      #2;
      check("ack_pending", 32'(ack), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ack_async_clr", 32'(ack), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(4'h4);
      rd(4'h8);
      chk_irq("irq_after_reset");

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
